// File: rtl/seg_scan_decoder_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | seg_scan_decoder_pkg : shared widths, hex glyph table, decode result |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
package seg_scan_decoder_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  // Active-high glyphs, bit6=a .. bit0=g.
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h7E;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h30;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h33;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h5F;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h70;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h7B;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h1F;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h4E;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h3D;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h47;

  typedef struct packed {
    logic               hit;
    logic [DIGIT_W-1:0] nibble;
  } seg_decode_t;

  function automatic logic [SEG_W-1:0] glyph_hi(input logic [DIGIT_W-1:0] d);
    case (d)
      4'h0: return GLYPH_0;
      4'h1: return GLYPH_1;
      4'h2: return GLYPH_2;
      4'h3: return GLYPH_3;
      4'h4: return GLYPH_4;
      4'h5: return GLYPH_5;
      4'h6: return GLYPH_6;
      4'h7: return GLYPH_7;
      4'h8: return GLYPH_8;
      4'h9: return GLYPH_9;
      4'hA: return GLYPH_A;
      4'hB: return GLYPH_B;
      4'hC: return GLYPH_C;
      4'hD: return GLYPH_D;
      4'hE: return GLYPH_E;
      default: return GLYPH_F;
    endcase
  endfunction

  function automatic logic [SEG_W-1:0] glyph_n(input logic [DIGIT_W-1:0] d);
    return ~glyph_hi(d);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_decoder_decode.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | seg_7_decode : active-low 7-segment pattern -> hex nibble + hit flag |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module seg_7_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [SEG_W-1:0]   seg_n,
  output logic               hit,
  output logic [DIGIT_W-1:0] nibble
);

  seg_decode_t res;

  // Glyphs are mutually distinct, so at most one entry can match; a miss leaves nibble 0.
  always_comb begin
    res = '0;
    for (int k = 0; k < 16; k++) begin
      if (seg_n == glyph_n(DIGIT_W'(k))) begin
        res.hit    = 1'b1;
        res.nibble = DIGIT_W'(k);
      end
    end
  end

  assign hit    = res.hit;
  assign nibble = res.nibble;

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | seg_scan_decoder : rebuilds hex frames from a multiplexed 7-seg bus  |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SEG_W-1:0]          seg_n,
  input  logic [DIGITS-1:0]         dig_n,
  output logic [DIGIT_W*DIGITS-1:0] value,
  output logic [DIGITS-1:0]         err,
  output logic                      frame_valid,
  output logic                      stale
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [SEG_W-1:0]          seg_s1_q, seg_s2_q, seg_prev_q;
  logic [DIGITS-1:0]         dig_s1_q, dig_s2_q, dig_prev_q;
  logic [CNT_W-1:0]          stable_q, stable_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic [DIGITS-1:0]         seen_q, seen_d;
  logic [DIGIT_W*DIGITS-1:0] slot_val_q, slot_val_d;
  logic [DIGITS-1:0]         slot_err_q, slot_err_d;
  logic [DIGIT_W*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]         err_q, err_d;
  logic                      frame_valid_q, frame_valid_d;

  logic [DIGITS-1:0]  dig_act, cap_mask, seen_all;
  logic               one_hot, steady, capture, frame_done;
  logic               dec_hit;
  logic [DIGIT_W-1:0] dec_nibble;

  seg_7_decode u_decode (
    .seg_n  (seg_s2_q),
    .hit    (dec_hit),
    .nibble (dec_nibble)
  );

  always_comb begin
    dig_act  = ~dig_s2_q;
    one_hot  = (dig_act != '0) && ((dig_act & (dig_act - DIGITS'(1))) == '0);
    steady   = one_hot && (seg_s2_q == seg_prev_q) && (dig_s2_q == dig_prev_q);
    stable_d = '0;
    if (steady) begin
      stable_d = (stable_q == CNT_W'(SETTLE)) ? stable_q : stable_q + CNT_W'(1);
    end
    // Fires only on the SETTLE-1 -> SETTLE step, so one capture per dwell.
    capture  = steady && (stable_q == CNT_W'(SETTLE - 1));
    cap_mask = capture ? dig_act : '0;

    slot_val_d = slot_val_q;
    slot_err_d = slot_err_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (cap_mask[i]) begin
        slot_val_d[i*DIGIT_W +: DIGIT_W] = dec_nibble;
        slot_err_d[i]                    = ~dec_hit;
      end
    end

    seen_all      = seen_q | cap_mask;
    frame_done    = capture && (&seen_all);
    seen_d        = frame_done ? '0 : seen_all;
    value_d       = frame_done ? slot_val_d : value_q;
    err_d         = frame_done ? slot_err_d : err_q;
    frame_valid_d = frame_done;

    tmo_d = '0;
    if (!capture) begin
      tmo_d = (tmo_q == TMO_W'(TIMEOUT)) ? tmo_q : tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_s1_q      <= '1;
      seg_s2_q      <= '1;
      seg_prev_q    <= '1;
      dig_s1_q      <= '1;
      dig_s2_q      <= '1;
      dig_prev_q    <= '1;
      stable_q      <= '0;
      tmo_q         <= '0;
      seen_q        <= '0;
      slot_val_q    <= '0;
      slot_err_q    <= '0;
      value_q       <= '0;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      seg_s1_q      <= seg_n;
      seg_s2_q      <= seg_s1_q;
      seg_prev_q    <= seg_s2_q;
      dig_s1_q      <= dig_n;
      dig_s2_q      <= dig_s1_q;
      dig_prev_q    <= dig_s2_q;
      stable_q      <= stable_d;
      tmo_q         <= tmo_d;
      seen_q        <= seen_d;
      slot_val_q    <= slot_val_d;
      slot_err_q    <= slot_err_d;
      value_q       <= value_d;
      err_q         <= err_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign value       = value_q;
  assign err         = err_q;
  assign frame_valid = frame_valid_q;
  assign stale       = (tmo_q == TMO_W'(TIMEOUT));

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_seg_scan_decoder : directed scans checked against a pin-level model |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module tb_seg_scan_decoder;

  localparam int DIGITS  = 4;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic [15:0] value;
  logic [3:0]  err;
  logic        frame_valid;
  logic        stale;

  int tests = 0;
  int fails = 0;
  int fv_cnt = 0;
  bit model_live = 1'b0;

  seg_scan_decoder #(.DIGITS(DIGITS), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_n       (dig_n),
    .value       (value),
    .err         (err),
    .frame_valid (frame_valid),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  // Active-low glyph table, index = nibble.
  localparam logic [6:0] TBL [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // Model state: pin samples from the last three edges, run of stable views, frame assembly.
  logic [6:0]  p1s, p2s, p3s;
  logic [3:0]  p1d, p2d, p3d;
  int          run, tmo;
  logic [3:0]  m_seen, m_serr, m_err;
  logic [15:0] m_slots, m_value;
  logic        m_fv;

  function automatic bit single_low(input logic [3:0] d);
    int zeros = 0;
    for (int i = 0; i < 4; i++) if (!d[i]) zeros++;
    return zeros == 1;
  endfunction

  task automatic model_step();
    bit   steady, cap, hit;
    int   idx;
    logic [3:0] nib;
    if (!rst_n) begin
      {p1s, p2s, p3s} = '1;
      {p1d, p2d, p3d} = '1;
      run = 0; tmo = 0;
      m_seen = 0; m_serr = 0; m_slots = 0;
      m_value = 0; m_err = 0; m_fv = 0;
    end else begin
      steady = single_low(p2d) && (p2d == p3d) && (p2s == p3s);
      run    = steady ? run + 1 : 0;
      cap    = steady && (run == SETTLE);
      m_fv   = 1'b0;
      if (cap) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (!p2d[i]) idx = i;
        hit = 1'b0; nib = 4'h0;
        for (int k = 0; k < 16; k++) if (TBL[k] == p2s) begin hit = 1'b1; nib = 4'(k); end
        m_slots[idx*4 +: 4] = nib;
        m_serr[idx]         = ~hit;
        m_seen[idx]         = 1'b1;
        if (m_seen == 4'hF) begin
          m_value = m_slots; m_err = m_serr; m_fv = 1'b1; m_seen = 0;
        end
      end
      tmo = cap ? 0 : ((tmo < TIMEOUT) ? tmo + 1 : tmo);
      p3s = p2s; p2s = p1s; p1s = seg_n;
      p3d = p2d; p2d = p1d; p1d = dig_n;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    model_live = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (model_live) begin
      tests++;
      if (value !== m_value || err !== m_err || frame_valid !== m_fv || stale !== (tmo == TIMEOUT)) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t value=%h/%h err=%b/%b fv=%b/%b stale=%b/%b (got/want)",
                 $time, value, m_value, err, m_err, frame_valid, m_fv, stale, (tmo == TIMEOUT));
      end
      if (frame_valid) fv_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic show(input int d, input logic [6:0] pat, input int cycles);
    dig_n = ~(4'(1) << d);
    seg_n = pat;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    dig_n = 4'hF;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                      input logic [6:0] d, input int dwell);
    show(0, a, dwell); show(1, b, dwell); show(2, c, dwell); show(3, d, dwell);
  endtask

  int fv0;

  initial begin
    rst_n = 1'b0; dig_n = 4'hF; seg_n = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    check("reset_value", value, 0);
    check("reset_err_fv_stale", {err, frame_valid, stale}, 0);
    rst_n = 1'b1;
    idle(4);

    fv0 = fv_cnt;
    scan(7'h4C, 7'h06, 7'h12, 7'h4F, 8); idle(8);
    check("frame1234_value", value, 16'h1234);
    check("frame1234_err", err, 4'b0000);
    check("frame1234_pulses", fv_cnt - fv0, 1);
    check("frame1234_stale", stale, 0);

    scan(7'h00, 7'h08, 7'h60, 7'h31, 8); idle(8);
    check("frame_cba8_value", value, 16'hCBA8);

    scan(7'h4C, 7'h06, 7'h7F, 7'h4F, 8); idle(8);
    check("blank_value", value, 16'h1034);
    check("blank_err", err, 4'b0100);
    scan(7'h4C, 7'h06, 7'h12, 7'h4F, 8); idle(8);
    check("recover_value", value, 16'h1234);
    check("recover_err", err, 4'b0000);

    fv0 = fv_cnt;
    show(0, 7'h4C, 8); show(1, 7'h24, 2); show(1, 7'h06, 8);
    show(2, 7'h12, 8); show(3, 7'h4F, 8); idle(8);
    check("glitch_value", value, 16'h1234);
    check("glitch_pulses", fv_cnt - fv0, 1);

    fv0 = fv_cnt;
    scan(7'h01, 7'h01, 7'h01, 7'h01, SETTLE - 1); idle(8);
    check("short_dwell_pulses", fv_cnt - fv0, 0);
    check("short_dwell_value", value, 16'h1234);

    fv0 = fv_cnt;
    show(0, 7'h4C, 8); show(1, 7'h06, 8);
    dig_n = 4'b1100; repeat (20) @(posedge clk); #1;
    idle(20);
    check("illegal_sel_pulses", fv_cnt - fv0, 0);
    show(2, 7'h12, 8); show(3, 7'h4F, 8); idle(8);
    check("illegal_sel_resume_pulses", fv_cnt - fv0, 1);
    check("illegal_sel_value", value, 16'h1234);

    idle(TIMEOUT + 5);
    check("timeout_stale", stale, 1);
    check("timeout_value_hold", value, 16'h1234);
    fv0 = fv_cnt;
    show(0, 7'h4C, 8);
    check("resume_stale_clear", stale, 0);
    show(1, 7'h06, 8); show(2, 7'h12, 8); show(3, 7'h4F, 8); idle(8);
    check("resume_pulses", fv_cnt - fv0, 1);
    check("resume_value", value, 16'h1234);

    show(0, 7'h01, 8); show(1, 7'h01, 8);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_value", value, 0);
    check("midreset_err_fv_stale", {err, frame_valid, stale}, 0);
    rst_n = 1'b1;
    fv0 = fv_cnt;
    idle(4);
    show(2, 7'h12, 8); show(3, 7'h4F, 8); idle(8);
    check("midreset_partial_pulses", fv_cnt - fv0, 0);
    show(0, 7'h08, 8); show(1, 7'h60, 8); idle(8);
    check("midreset_pulses", fv_cnt - fv0, 1);
    check("midreset_frame_value", value, 16'h12BA);
    check("midreset_frame_err", err, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
